calc_engine: RTL

Parametrised second-generation keypad calculator core. It accepts decoded key events from the keypad interface and drives a W-bit hexadecimal value to the digital display interface. Compared with the first-generation core it adds:
- configurable digit count
- subtraction and clear-entry
- chained operations
- a multi-cycle shift-add multiplier with a busy indication

It runs from the single system clock.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/calc_seq_mult.sv | 68 ++++++
 rtl/calc_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator core: key commands, operators
// and controller states.
package calc_pkg;

  localparam logic [2:0] KEY_PLUS  = 3'd1;
  localparam logic [2:0] KEY_TIMES = 3'd2;
  localparam logic [2:0] KEY_EQ    = 3'd3;
  localparam logic [2:0] KEY_CA    = 3'd4;
  localparam logic [2:0] KEY_MINUS = 3'd5;
  localparam logic [2:0] KEY_CE    = 3'd6;

  typedef enum logic [1:0] {
    OP_PLUS  = 2'd0,
    OP_MINUS = 2'd1,
    OP_TIMES = 2'd2
  } op_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL      = 2'd1;
  localparam logic [1:0] ST_CHAIN_WB = 2'd2;

  function automatic logic is_arith_key(input logic [2:0] cmd);
    return (cmd == KEY_PLUS) || (cmd == KEY_MINUS) || (cmd == KEY_TIMES);
  endfunction

  function automatic op_t key_to_op(input logic [2:0] cmd);
    case (cmd)
      KEY_MINUS: return OP_MINUS;
      KEY_TIMES: return OP_TIMES;
      default:   return OP_PLUS;
    endcase
  endfunction

endpackage

// File: rtl/calc_seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, W cycles in
// total, the first iteration folded into the start cycle.
module calc_seq_mult #(
  parameter int W = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   mcand_r;
  logic [2*W-1:0] acc_r;
  logic [CW-1:0]  cnt_r;
  logic           run_r;
  logic           done_r;

  // Upper half accumulates the partial sum; the multiplier shifts out of the lower half.
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] sum;
    sum = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? m : {W{1'b0}})};
    return {sum, p[W-1:1]};
  endfunction

  // Iteration control and product accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r <= {W{1'b0}};
      acc_r   <= {(2*W){1'b0}};
      cnt_r   <= {CW{1'b0}};
      run_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (abort) begin
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      mcand_r <= a;
      acc_r   <= step({{W{1'b0}}, b}, a);
      cnt_r   <= CW'(1);
      run_r   <= 1'b1;
      done_r  <= 1'b0;
    end else if (run_r) begin
      acc_r <= step(acc_r, mcand_r);
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CW'(W - 1)) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = run_r;
  assign done = done_r;
  assign prod = acc_r;

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator core: key decode, entry/accumulator registers, add/sub
// datapath and the controller sequencing the multiplier.
module calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 5,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         newkey,
  input  logic [4:0]   keycode,
  output logic [W-1:0] x,
  output logic         led,
  output logic         busy
);

  logic [W-1:0] x_r;
  logic [W-1:0] y_r;
  op_t          op_r;
  logic         entry_r;
  logic         pend_r;
  logic         led_r;
  logic [1:0]   state_r;
  logic         busy_r;
  logic         chain_r;

  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic [W-1:0] res_s;
  logic         flag_s;
  logic [2:0]   cmd_s;
  logic         ca_s;
  logic         accept_s;
  logic         mult_start_s;

  logic           mult_busy;
  logic           mult_done;
  logic [2*W-1:0] mult_prod;

  // Add/sub result and carry/borrow for the current operator.
  always_comb begin
    sum_s  = {1'b0, y_r} + {1'b0, x_r};
    diff_s = {1'b0, y_r} - {1'b0, x_r};
    if (op_r == OP_MINUS) begin
      res_s  = diff_s[W-1:0];
      flag_s = diff_s[W];
    end else begin
      res_s  = sum_s[W-1:0];
      flag_s = sum_s[W];
    end
  end

  // Key qualification; busy is judged from the registered state only.
  always_comb begin
    cmd_s    = keycode[2:0];
    ca_s     = newkey && !keycode[4] && (cmd_s == KEY_CA);
    accept_s = newkey && (state_r == ST_IDLE);
    if (accept_s && !keycode[4] && (op_r == OP_TIMES)) begin
      mult_start_s = (cmd_s == KEY_EQ) || (entry_r && pend_r && is_arith_key(cmd_s));
    end else begin
      mult_start_s = 1'b0;
    end
  end

  calc_seq_mult #(.W(W)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mult_start_s),
    .abort (ca_s),
    .a     (y_r),
    .b     (x_r),
    .busy  (mult_busy),
    .done  (mult_done),
    .prod  (mult_prod)
  );

  // Controller and operand register updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r     <= {W{1'b0}};
      y_r     <= {W{1'b0}};
      op_r    <= OP_PLUS;
      entry_r <= 1'b0;
      pend_r  <= 1'b0;
      led_r   <= 1'b0;
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      chain_r <= 1'b0;
    end else if (ca_s) begin
      x_r     <= {W{1'b0}};
      y_r     <= {W{1'b0}};
      op_r    <= OP_PLUS;
      entry_r <= 1'b0;
      pend_r  <= 1'b0;
      led_r   <= 1'b0;
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      chain_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (newkey && keycode[4]) begin
            if (x_r[W-1:W-4] == 4'd0) begin
              x_r     <= {x_r[W-5:0], keycode[3:0]};
              entry_r <= 1'b1;
              led_r   <= 1'b0;
            end
          end else if (newkey) begin
            case (cmd_s)
              KEY_PLUS, KEY_MINUS, KEY_TIMES: begin
                op_r    <= key_to_op(cmd_s);
                entry_r <= 1'b0;
                pend_r  <= 1'b1;
                led_r   <= 1'b0;
                if (entry_r && pend_r && (op_r == OP_TIMES)) begin
                  state_r <= ST_MUL;
                  busy_r  <= 1'b1;
                  chain_r <= 1'b1;
                end else if (entry_r && pend_r) begin
                  y_r <= res_s;
                  x_r <= {W{1'b0}};
                end else begin
                  y_r <= x_r;
                  x_r <= {W{1'b0}};
                end
              end
              KEY_EQ: begin
                entry_r <= 1'b0;
                pend_r  <= 1'b0;
                if (op_r == OP_TIMES) begin
                  state_r <= ST_MUL;
                  busy_r  <= 1'b1;
                  chain_r <= 1'b0;
                end else begin
                  x_r   <= res_s;
                  led_r <= flag_s;
                end
              end
              KEY_CE: begin
                x_r     <= {W{1'b0}};
                entry_r <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mult_done && chain_r) begin
            state_r <= ST_CHAIN_WB;
          end else if (mult_done) begin
            x_r     <= mult_prod[W-1:0];
            led_r   <= |mult_prod[2*W-1:W];
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (!mult_busy) begin
            // Multiplier lost its run without finishing: fall back to idle.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CHAIN_WB: begin
          y_r     <= mult_prod[W-1:0];
          x_r     <= {W{1'b0}};
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          chain_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          chain_r <= 1'b0;
        end
      endcase
    end
  end

  assign x    = x_r;
  assign led  = led_r;
  assign busy = busy_r;

endmodule
